hilo_div_unit: RTL and testbench
================================

# hilo_div_unit

Holds the architectural HI/LO register pair and sits directly downstream of the ALU: it captures the ALU's 64-bit HiLoWrite result (MULT/MULTU/MADD/MSUB) and feeds the current {HI,LO} back to the ALU on HiLoRead for MADD/MSUB accumulation. It also executes MTHI/MTLO writes. With the divider configured in, it runs DIV/DIVU as a multi-cycle iterative operation and asserts Busy so the pipeline stalls until the quotient and remainder are written.

## Interface
Parameters:
- None. Widths are fixed: 32-bit operands, 64-bit HI/LO pair.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- HiLoEn  in  1  ALU write enable for the HI/LO pair.
- HiLoWrite  in  64  ALU result; [63:32] goes to HI, [31:0] goes to LO.
- MtHi  in  1  MTHI write enable.
- MtLo  in  1  MTLO write enable.
- MoveData  in  32  data source for MTHI/MTLO.
- DivStart  in  1  starts a divide; sampled only in IDLE.
- DivSigned  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with DivStart.
- DivA  in  32  dividend; sampled with DivStart.
- DivB  in  32  divisor; sampled with DivStart.
- HiLoRead  out  64  {HI,LO}, driven directly from the registers.
- Busy  out  1  divide in progress; the pipeline stalls while it is high.
- DivDone  out  1  one-cycle pulse marking the completion of a divide.

## Operation
- Reset:
  - HI = 0 and LO = 0, so HiLoRead = 0.
  - Busy = 0 and DivDone = 0.
  - The state machine returns to IDLE.
  - Reset asserted mid-divide aborts it; no partial result is written.
- Write priority in IDLE, highest first:
  - DivStart: starts the divide and drops every other write in that cycle.
  - HiLoEn: writes the full 64 bits.
  - MtHi / MtLo: each writes its half from MoveData; both may apply in the same cycle.
- While Busy = 1:
  - HiLoEn, MtHi, MtLo and DivStart are all ignored.
  - HiLoRead keeps its pre-divide value.
- State machine (IDLE → DIV → FIX → IDLE):
  - IDLE → DIV on DivStart. Latch |DivA| and |DivB| (raw values for DIVU), the two operand signs, and the divide-by-zero flag. Clear the counter.
  - DIV: one restoring shift/subtract step per cycle on a 33-bit partial remainder. The counter runs 0..31; after step 31 go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse DivDone, return to IDLE.
- Signed results:
  - The quotient truncates toward zero; it is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0.
- Divide by zero (both modes): LO = 0xFFFFFFFF and HI = DivA. Latency is unchanged.
- Results: LO = quotient, HI = remainder.

## Timing
- Writes via HiLoEn/MtHi/MtLo land on the sampling edge and are visible on HiLoRead in the next cycle. There is no internal bypass.
- Let the edge that samples DivStart be edge 0:
  - Busy rises after edge 0 and stays high for 33 cycles.
  - Edges 1..32 perform the 32 DIV steps.
  - At edge 33, in FIX, HI/LO are written, Busy falls and DivDone goes high for exactly one cycle.
  - The new HI/LO is visible from edge 33 onward.
- A new DivStart is accepted at edge 34 at the earliest, when the unit is back in IDLE.
- Back-to-back HiLoEn writes on consecutive cycles each take effect.

## Configuration
- HILO_DIV_EN defined: the divider, its state machine and the Busy/DivDone logic are compiled in as described above.
- HILO_DIV_EN undefined:
  - The divider is removed.
  - DivStart, DivSigned, DivA and DivB are ignored.
  - Busy and DivDone are tied to 0.
  - Only the HiLoEn / MtHi / MtLo write paths remain.

## Test plan
- Reset, then HiLoEn=1 with HiLoWrite=0x00000001_FFFFFFFE → HiLoRead = 0x00000001_FFFFFFFE one cycle later. Assert Rst mid-test → HiLoRead = 0 immediately, without waiting for a clock edge.
- Same cycle: MtHi=1, MtLo=1, MoveData=0x12345678 → HI = LO = 0x12345678. Then HiLoEn and MtLo together → the HiLoEn value wins.
- DIVU with DivA=100, DivB=7 → Busy high for 33 cycles, DivDone pulse at edge 33, LO = 14, HI = 2. A HiLoEn write issued while Busy is ignored.
- DIV with DivA=-7 (0xFFFFFFF9), DivB=2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIV with 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIV with DivA=5, DivB=0 → LO = 0xFFFFFFFF, HI = 5 after 33 cycles. Rst at edge 10 of a divide → Busy = 0, HI = LO = 0, no DivDone.
- Build without HILO_DIV_EN: pulse DivStart → Busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/hilo_div_unit_if.sv
// HI/LO unit port bundle: ALU and move writes in, {HI,LO} readback and
// divider status out. Clk/Rst are plain ports on the unit itself.
interface hilo_div_unit_if;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] MoveData;
    logic        DivStart;
    logic        DivSigned;
    logic [31:0] DivA;
    logic [31:0] DivB;
    logic [63:0] HiLoRead;
    logic        Busy;
    logic        DivDone;

    modport master (
        output HiLoEn, HiLoWrite, MtHi, MtLo, MoveData,
        output DivStart, DivSigned, DivA, DivB,
        input  HiLoRead, Busy, DivDone
    );

    modport slave (
        input  HiLoEn, HiLoWrite, MtHi, MtLo, MoveData,
        input  DivStart, DivSigned, DivA, DivB,
        output HiLoRead, Busy, DivDone
    );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with ALU/MTHI/MTLO write paths and an optional 32-cycle
// restoring divider, compiled in when the macro HILO_DIV_EN is defined.
module hilo_div_unit (
    input logic            Clk,
    input logic            Rst,
    hilo_div_unit_if.slave bus
);
    logic [31:0] hi;
    logic [31:0] lo;
    logic        idle;
    logic        div_start;
    logic        div_wr;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

`ifdef HILO_DIV_EN
    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic               busy;
    logic               done;
    logic signed [31:0] a_raw;
    logic [31:0]        b_mag;
    logic [31:0]        rem;
    logic [31:0]        quo;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [32:0]        shifted;
    logic [32:0]        diff;

    function automatic logic [31:0] op_mag(input logic signed [31:0] v, input logic sgn);
        return (sgn && v < 0) ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        logic signed [31:0] s;
        s = signed'(mag);
        return neg ? 32'(-s) : mag;
    endfunction

    assign idle      = (state == IDLE);
    assign div_start = idle && bus.DivStart;
    assign div_wr    = (state == FIX);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.DivStart) begin
                    state <= DIV;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                DIV: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Restoring step: the shifted remainder needs 33 bits, the kept one never exceeds the divisor.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, b_mag};
    end

    always_ff @(posedge Clk) begin
        if (div_start) begin
            a_raw <= signed'(bus.DivA);
            b_mag <= op_mag(signed'(bus.DivB), bus.DivSigned);
            quo   <= op_mag(signed'(bus.DivA), bus.DivSigned);
            rem   <= '0;
            neg_q <= bus.DivSigned && (bus.DivA[31] ^ bus.DivB[31]);
            neg_r <= bus.DivSigned && bus.DivA[31];
            dz    <= (bus.DivB == 32'd0);
        end else if (state == DIV) begin
            rem <= diff[32] ? shifted[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
        end
    end

    assign div_lo      = dz ? 32'hFFFF_FFFF : apply_sign(quo, neg_q);
    assign div_hi      = dz ? 32'(a_raw)    : apply_sign(rem, neg_r);
    assign bus.Busy    = busy;
    assign bus.DivDone = done;
`else
    logic unused_div_inputs;

    assign unused_div_inputs = ^{bus.DivStart, bus.DivSigned, bus.DivA, bus.DivB};
    assign idle        = 1'b1;
    assign div_start   = 1'b0;
    assign div_wr      = 1'b0;
    assign div_hi      = '0;
    assign div_lo      = '0;
    assign bus.Busy    = 1'b0;
    assign bus.DivDone = 1'b0;
`endif

    // A starting divide suppresses every other write in its cycle; nothing else writes until IDLE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_wr) begin
            hi <= div_hi;
            lo <= div_lo;
        end else if (idle && !div_start) begin
            if (bus.HiLoEn) begin
                hi <= bus.HiLoWrite[63:32];
                lo <= bus.HiLoWrite[31:0];
            end else begin
                if (bus.MtHi) hi <= bus.MoveData;
                if (bus.MtLo) lo <= bus.MoveData;
            end
        end
    end

    assign bus.HiLoRead = {hi, lo};
endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed + randomized bench for hilo_div_unit; divider checks apply when
// HILO_DIV_EN is defined, otherwise the divide inputs must have no effect.
module tb_hilo_div_unit;
    logic Clk = 1'b0;
    logic Rst = 1'b1;

    hilo_div_unit_if bus();

    hilo_div_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int          total  = 0;
    int          passed = 0;
    logic [63:0] model;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs;
        bus.HiLoEn    = 1'b0;
        bus.HiLoWrite = '0;
        bus.MtHi      = 1'b0;
        bus.MtLo      = 1'b0;
        bus.MoveData  = '0;
        bus.DivStart  = 1'b0;
        bus.DivSigned = 1'b0;
        bus.DivA      = '0;
        bus.DivB      = '0;
    endtask

`ifdef HILO_DIV_EN
    // Reference: {HI,LO} = {remainder, quotient} from 64-bit integer division.
    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           input bit poke, input string tag);
        logic [63:0] exp;
        logic [63:0] pre;
        int busy_cycles;
        int early_done;
        exp = div_ref(a, b, sgn);
        pre = model;
        busy_cycles = 0;
        early_done  = 0;
        bus.DivStart  = 1'b1;
        bus.DivSigned = sgn;
        bus.DivA      = a;
        bus.DivB      = b;
        bus.HiLoEn    = 1'b1;
        bus.HiLoWrite = 64'h0BAD_0BAD_0BAD_0BAD;
        tick;
        idle_inputs;
        if (bus.Busy) busy_cycles++;
        for (int i = 1; i <= 32; i++) begin
            if (poke && i == 5) begin
                bus.HiLoEn    = 1'b1;
                bus.HiLoWrite = 64'hDEAD_BEEF_CAFE_F00D;
                bus.MtHi      = 1'b1;
                bus.MtLo      = 1'b1;
                bus.MoveData  = 32'h5555_AAAA;
                bus.DivStart  = 1'b1;
                bus.DivA      = 32'd9;
                bus.DivB      = 32'd1;
            end
            tick;
            idle_inputs;
            if (bus.Busy) busy_cycles++;
            if (bus.DivDone) early_done++;
        end
        check({tag, "_hold"}, bus.HiLoRead, pre);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({tag, "_early_done"}, 64'(early_done), 64'd0);
        tick;
        check({tag, "_busy_fall"}, 64'(bus.Busy), 64'd0);
        check({tag, "_done"}, 64'(bus.DivDone), 64'd1);
        check({tag, "_result"}, bus.HiLoRead, exp);
        tick;
        check({tag, "_done_pulse"}, 64'(bus.DivDone), 64'd0);
        model = exp;
    endtask
`endif

    initial begin
        logic [63:0] w;
        logic        en, mh, ml;
        logic [31:0] md;
        int          stray_done;

        idle_inputs;
        model = '0;
        tick;
        tick;
        check("reset_hilo", bus.HiLoRead, 64'd0);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.DivDone), 64'd0);
        Rst = 1'b0;

        bus.HiLoEn    = 1'b1;
        bus.HiLoWrite = 64'h0000_0001_FFFF_FFFE;
        tick;
        idle_inputs;
        check("hiloen_write", bus.HiLoRead, 64'h0000_0001_FFFF_FFFE);

        bus.MtHi     = 1'b1;
        bus.MtLo     = 1'b1;
        bus.MoveData = 32'h1234_5678;
        tick;
        idle_inputs;
        check("mthi_mtlo", bus.HiLoRead, 64'h1234_5678_1234_5678);

        bus.HiLoEn    = 1'b1;
        bus.HiLoWrite = 64'hA5A5_0000_0000_5A5A;
        bus.MtLo      = 1'b1;
        bus.MoveData  = 32'hFFFF_0000;
        tick;
        idle_inputs;
        check("hiloen_beats_mtlo", bus.HiLoRead, 64'hA5A5_0000_0000_5A5A);

        bus.HiLoEn    = 1'b1;
        bus.HiLoWrite = 64'h1111_2222_3333_4444;
        tick;
        check("b2b_first", bus.HiLoRead, 64'h1111_2222_3333_4444);
        bus.HiLoWrite = 64'h5555_6666_7777_8888;
        tick;
        idle_inputs;
        check("b2b_second", bus.HiLoRead, 64'h5555_6666_7777_8888);
        model = 64'h5555_6666_7777_8888;

        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 3) == 0);
            mh = 1'($urandom_range(0, 1));
            ml = 1'($urandom_range(0, 1));
            md = $urandom;
            w  = {$urandom, $urandom};
            bus.HiLoEn    = en;
            bus.HiLoWrite = w;
            bus.MtHi      = mh;
            bus.MtLo      = ml;
            bus.MoveData  = md;
            if (en) model = w;
            else begin
                if (mh) model[63:32] = md;
                if (ml) model[31:0]  = md;
            end
            tick;
            idle_inputs;
            check("random_write", bus.HiLoRead, model);
        end

`ifdef HILO_DIV_EN
        run_div(32'd100, 32'd7, 1'b0, 1'b1, "divu_100_7");
        check("divu_100_7_value", bus.HiLoRead, {32'd2, 32'd14});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
        check("div_m7_2_value", bus.HiLoRead, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_min_m1");
        check("div_min_m1_value", bus.HiLoRead, {32'd0, 32'h8000_0000});
        run_div(32'd5, 32'd0, 1'b1, 1'b0, "div_5_0");
        check("div_5_0_value", bus.HiLoRead, {32'd5, 32'hFFFF_FFFF});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "divu_big_2");
        for (int i = 0; i < 6; i++)
            run_div($urandom, $urandom >> $urandom_range(0, 30), 1'($urandom_range(0, 1)), 1'b0, "div_random");

        bus.DivStart  = 1'b1;
        bus.DivSigned = 1'b0;
        bus.DivA      = 32'd1000;
        bus.DivB      = 32'd3;
        tick;
        idle_inputs;
        for (int i = 1; i < 10; i++) tick;
        #2;
        Rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_hilo", bus.HiLoRead, 64'd0);
        check("abort_done", 64'(bus.DivDone), 64'd0);
        tick;
        Rst = 1'b0;
        stray_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bus.DivDone || bus.Busy) stray_done++;
        end
        check("abort_no_done", 64'(stray_done), 64'd0);
        check("abort_hilo_stays", bus.HiLoRead, 64'd0);
        model = '0;

        bus.HiLoEn    = 1'b1;
        bus.HiLoWrite = 64'hFEED_FACE_0123_4567;
        tick;
        idle_inputs;
        model = 64'hFEED_FACE_0123_4567;
        check("post_abort_write", bus.HiLoRead, model);
`else
        bus.DivStart  = 1'b1;
        bus.DivSigned = 1'b1;
        bus.DivA      = 32'd100;
        bus.DivB      = 32'd7;
        tick;
        check("nodiv_busy", 64'(bus.Busy), 64'd0);
        check("nodiv_hilo", bus.HiLoRead, model);
        bus.HiLoEn    = 1'b1;
        bus.HiLoWrite = 64'hFEED_FACE_0123_4567;
        tick;
        idle_inputs;
        model = 64'hFEED_FACE_0123_4567;
        check("nodiv_write_with_start", bus.HiLoRead, model);
        stray_done = 0;
        for (int i = 0; i < 36; i++) begin
            tick;
            if (bus.DivDone || bus.Busy) stray_done++;
        end
        check("nodiv_no_done", 64'(stray_done), 64'd0);
        check("nodiv_hilo_stays", bus.HiLoRead, model);
`endif

        #2;
        Rst = 1'b1;
        #1;
        check("async_reset_hilo", bus.HiLoRead, 64'd0);
        check("async_reset_busy", 64'(bus.Busy), 64'd0);
        tick;
        Rst = 1'b0;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
